// File: rtl/power_gate_seq_if.sv
// Power-gate sequencer bundle: request/ack inputs and the registered control outputs.
//   sleep_req, wake_req : level requests to power the gated domain down / up
//   pwr_ack             : power-switch chain status (1 = domain powered), asynchronous
//   pwr_en, iso_en      : power-switch enable, isolation clamp enable
//   clk_en              : gated-domain clock enable
//   save, restore       : retention strobes to the always-on flops
//   busy, err           : sequence in progress, sticky ack-timeout flag
//   state               : current FSM encoding
// master = environment side (drives requests/ack), slave = the sequencer.
interface power_gate_seq_if;
    logic       sleep_req;
    logic       wake_req;
    logic       pwr_ack;
    logic       pwr_en;
    logic       iso_en;
    logic       clk_en;
    logic       save;
    logic       restore;
    logic       busy;
    logic       err;
    logic [3:0] state;

    modport master (
        output sleep_req, wake_req, pwr_ack,
        input  pwr_en, iso_en, clk_en, save, restore, busy, err, state
    );

    modport slave (
        input  sleep_req, wake_req, pwr_ack,
        output pwr_en, iso_en, clk_en, save, restore, busy, err, state
    );
endinterface

// File: rtl/power_gate_seq.sv
// Power-gating sequencer for one switchable domain. Walks the domain down
// (stop clock, isolate, save retention, switch off) and back up (switch on,
// restore, de-isolate, start clock). All state lives on falling CLK edges to
// line up with the negative-edge always-on retention flops.
//   CLK  : clock, falling edge active
//   RSTB : asynchronous active-low reset
//   bus  : power_gate_seq_if.slave (requests, pwr_ack, registered control outputs)
// Parameters:
//   SAVE_CYC    : cycles spent in SAVE and in RESTORE (1..255)
//   ACK_TIMEOUT : wait cycles in PWR_OFF / PWR_ON before err is raised (1..255)
module power_gate_seq #(
    parameter int unsigned SAVE_CYC    = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input logic             CLK,
    input logic             RSTB,
    power_gate_seq_if.slave bus
);
    typedef enum logic [3:0] {
        StOn       = 4'd0,
        StStopClk  = 4'd1,
        StIsolate  = 4'd2,
        StSave     = 4'd3,
        StPwrOff   = 4'd4,
        StOff      = 4'd5,
        StPwrOn    = 4'd6,
        StRestore  = 4'd7,
        StDeiso    = 4'd8,
        StStartClk = 4'd9
    } state_e;

    localparam logic [7:0] DwellLast = 8'(SAVE_CYC - 1);
    localparam logic [7:0] AckLimit  = 8'(ACK_TIMEOUT);

    // Held as a raw 4-bit vector so the unused encodings 10-15 are representable
    // and fall through to the recovery branch.
    logic [3:0] state_q;
    state_e     state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       ack_s1_q, ack_s2_q;
    logic       waiting;
    logic       err_q, err_d;
    logic       pwr_en_q, pwr_en_d;
    logic       iso_en_q, iso_en_d;
    logic       clk_en_q, clk_en_d;
    logic       save_q, save_d;
    logic       restore_q, restore_d;
    logic       busy_q, busy_d;

    always_comb begin
        cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
        waiting = 1'b0;
        state_d = StOn;
        case (state_q)
            StOn:       state_d = bus.sleep_req ? StStopClk : StOn;
            StStopClk:  state_d = StIsolate;
            StIsolate:  state_d = StSave;
            StSave:     state_d = (cnt_q >= DwellLast) ? StPwrOff : StSave;
            StPwrOff: begin
                waiting = 1'b1;
                state_d = ack_s2_q ? StPwrOff : StOff;
            end
            StOff:      state_d = bus.wake_req ? StPwrOn : StOff;
            StPwrOn: begin
                waiting = 1'b1;
                state_d = ack_s2_q ? StRestore : StPwrOn;
            end
            StRestore:  state_d = (cnt_q >= DwellLast) ? StDeiso : StRestore;
            StDeiso:    state_d = StStartClk;
            StStartClk: state_d = StOn;
            default:    state_d = StOn;
        endcase

        cnt_d = (state_d != state_q) ? 8'd0 : cnt_inc;
        // Timeout only flags; the FSM keeps waiting for the ack.
        err_d = err_q | (waiting && (state_d == state_q) && (cnt_inc >= AckLimit));

        // Moore outputs decoded from the next state so they register on the same edge.
        clk_en_d  = (state_d == StOn) || (state_d == StStartClk);
        iso_en_d  = (state_d >= StIsolate) && (state_d <= StRestore);
        save_d    = (state_d == StSave);
        restore_d = (state_d == StRestore);
        pwr_en_d  = !((state_d == StPwrOff) || (state_d == StOff));
        busy_d    = !((state_d == StOn) || (state_d == StOff));
    end

    always_ff @(negedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q   <= StOn;
            cnt_q     <= 8'd0;
            ack_s1_q  <= 1'b1;
            ack_s2_q  <= 1'b1;
            err_q     <= 1'b0;
            pwr_en_q  <= 1'b1;
            iso_en_q  <= 1'b0;
            clk_en_q  <= 1'b1;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_s1_q  <= bus.pwr_ack;
            ack_s2_q  <= ack_s1_q;
            err_q     <= err_d;
            pwr_en_q  <= pwr_en_d;
            iso_en_q  <= iso_en_d;
            clk_en_q  <= clk_en_d;
            save_q    <= save_d;
            restore_q <= restore_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.pwr_en  = pwr_en_q;
    assign bus.iso_en  = iso_en_q;
    assign bus.clk_en  = clk_en_q;
    assign bus.save    = save_q;
    assign bus.restore = restore_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_power_gate_seq.sv
// Bench for power_gate_seq: two instances (default timeout, and ACK_TIMEOUT=4),
// a cycle-level reference model per instance compared on every rising edge,
// and directed scenarios with hand-computed expectations.
module tb_power_gate_seq;
    localparam int SaveCyc = 2;
    localparam int TmoA    = 15;
    localparam int TmoB    = 4;

    logic CLK  = 1'b0;
    logic RSTB = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    power_gate_seq_if bus_a ();
    power_gate_seq_if bus_b ();

    power_gate_seq #(.SAVE_CYC(SaveCyc), .ACK_TIMEOUT(TmoA)) dut_a (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus_a)
    );

    power_gate_seq #(.SAVE_CYC(SaveCyc), .ACK_TIMEOUT(TmoB)) dut_b (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus_b)
    );

    always #5 CLK = ~CLK;

    // Reference model: phase number walks 0..9 in order; each phase either
    // lasts a fixed number of cycles or waits on a condition.
    typedef struct packed {
        logic [3:0] st;
        logic [7:0] cnt;
        logic       err;
        logic       s1;
        logic       s2;
    } mdl_t;

    localparam mdl_t RstMdl = '{st: 4'd0, cnt: 8'd0, err: 1'b0, s1: 1'b1, s2: 1'b1};

    mdl_t m_a = RstMdl;
    mdl_t m_b = RstMdl;

    function automatic mdl_t step(mdl_t m, logic slp, logic wk, logic ack, int dwell, int tmo);
        mdl_t n   = m;
        int   st  = int'(m.st);
        int   cnt = int'(m.cnt);
        bit   go;
        n.s1 = ack;
        n.s2 = m.s1;
        case (st)
            0:       go = slp;
            5:       go = wk;
            3, 7:    go = (cnt + 1 >= dwell);
            4:       go = !m.s2;
            6:       go = m.s2;
            default: go = 1'b1;
        endcase
        if (st > 9) begin
            n.st  = 4'd0;
            n.cnt = 8'd0;
        end else if (go) begin
            n.st  = 4'((st + 1) % 10);
            n.cnt = 8'd0;
        end else begin
            cnt   = (cnt < 255) ? cnt + 1 : 255;
            n.cnt = 8'(cnt);
            if ((st == 4 || st == 6) && cnt >= tmo) n.err = 1'b1;
        end
        return n;
    endfunction

    // {pwr_en, iso_en, clk_en, save, restore, busy, err, state}
    function automatic logic [10:0] expect_of(mdl_t m);
        int s = int'(m.st);
        return {!(s == 4 || s == 5), (s >= 2 && s <= 7), (s == 0 || s == 9),
                (s == 3), (s == 7), !(s == 0 || s == 5), m.err, m.st};
    endfunction

    always @(negedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            m_a <= RstMdl;
            m_b <= RstMdl;
        end else begin
            m_a <= step(m_a, bus_a.sleep_req, bus_a.wake_req, bus_a.pwr_ack, SaveCyc, TmoA);
            m_b <= step(m_b, bus_b.sleep_req, bus_b.wake_req, bus_b.pwr_ack, SaveCyc, TmoB);
        end
    end

    logic [10:0] act_a, act_b;
    assign act_a = {bus_a.pwr_en, bus_a.iso_en, bus_a.clk_en, bus_a.save, bus_a.restore,
                    bus_a.busy, bus_a.err, bus_a.state};
    assign act_b = {bus_b.pwr_en, bus_b.iso_en, bus_b.clk_en, bus_b.save, bus_b.restore,
                    bus_b.busy, bus_b.err, bus_b.state};

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h, expected %03h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Whole-output comparison against the model, away from the active falling edge.
    always @(posedge CLK) begin
        chk_vec("cycle_a", act_a, expect_of(m_a));
        chk_vec("cycle_b", act_b, expect_of(m_b));
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [3:0] cur_state(input bit sel);
        return sel ? bus_b.state : bus_a.state;
    endfunction

    task automatic wait_for(input bit sel, input logic [3:0] tgt, input string nm);
        for (int i = 0; i < 40; i++) begin
            if (cur_state(sel) == tgt) break;
            tick();
        end
        chk(nm, int'(cur_state(sel)), int'(tgt));
    endtask

    int seq_sleep [5] = '{1, 2, 3, 3, 4};
    int seq_wake  [7] = '{6, 6, 7, 7, 8, 9, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int saves;
        int restores;
        int n;

        bus_a.sleep_req = 1'b0; bus_a.wake_req = 1'b0; bus_a.pwr_ack = 1'b1;
        bus_b.sleep_req = 1'b0; bus_b.wake_req = 1'b0; bus_b.pwr_ack = 1'b1;
        #1 RSTB = 1'b0;
        #2;
        chk("rst_state", int'(bus_a.state), 0);
        chk("rst_pwr_en", int'(bus_a.pwr_en), 1);
        chk("rst_clk_en", int'(bus_a.clk_en), 1);
        chk("rst_iso_en", int'(bus_a.iso_en), 0);
        chk("rst_busy", int'(bus_a.busy), 0);
        chk("rst_err", int'(bus_b.err), 0);
        tick();
        tick();
        RSTB = 1'b1;
        tick();

        // Sleep: one-cycle request, ack drops 3 cycles after pwr_en falls.
        saves = 0;
        bus_a.sleep_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                bus_a.sleep_req = 1'b0;
                chk("sleep_clk_off", int'(bus_a.clk_en), 0);
            end
            chk("sleep_seq", int'(bus_a.state), seq_sleep[i]);
            saves += int'(bus_a.save);
        end
        chk("sleep_pwr_en_low", int'(bus_a.pwr_en), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            saves += int'(bus_a.save);
        end
        bus_a.pwr_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            saves += int'(bus_a.save);
            if (bus_a.state == 4'd5) break;
        end
        chk("ack_to_off_cycles", n, 3);
        chk("save_cycles", saves, 2);
        chk("off_busy", int'(bus_a.busy), 0);
        chk("off_err", int'(bus_a.err), 0);

        // Wake: ack rises 2 cycles after pwr_en returns.
        bus_a.wake_req = 1'b1;
        tick();
        bus_a.wake_req = 1'b0;
        chk("wake_pwr_on", int'(bus_a.state), 6);
        chk("wake_pwr_en", int'(bus_a.pwr_en), 1);
        tick();
        tick();
        bus_a.pwr_ack = 1'b1;
        restores = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("wake_seq", int'(bus_a.state), seq_wake[i]);
            restores += int'(bus_a.restore);
            if (i == 4) chk("deiso_iso_off", int'(bus_a.iso_en), 0);
            if (i == 5) chk("start_clk_en", int'(bus_a.clk_en), 1);
        end
        chk("restore_cycles", restores, 2);

        // Both requests in ON: sleep wins; held wake starts wake right after OFF.
        bus_a.sleep_req = 1'b1;
        bus_a.wake_req  = 1'b1;
        tick();
        bus_a.sleep_req = 1'b0;
        chk("both_sleep_wins", int'(bus_a.state), 1);
        wait_for(1'b0, 4'd4, "both_pwr_off");
        bus_a.pwr_ack = 1'b0;
        wait_for(1'b0, 4'd5, "both_off");
        tick();
        chk("held_wake_next", int'(bus_a.state), 6);
        bus_a.wake_req = 1'b0;
        bus_a.pwr_ack  = 1'b1;
        wait_for(1'b0, 4'd0, "both_back_on");

        // Reset pulse while in SAVE.
        bus_a.sleep_req = 1'b1;
        tick();
        bus_a.sleep_req = 1'b0;
        tick();
        tick();
        chk("pre_rst_save", int'(bus_a.save), 1);
        RSTB = 1'b0;
        #1;
        chk("rst_mid_state", int'(bus_a.state), 0);
        chk("rst_mid_save", int'(bus_a.save), 0);
        chk("rst_mid_iso", int'(bus_a.iso_en), 0);
        chk("rst_mid_clk_en", int'(bus_a.clk_en), 1);
        chk("rst_mid_busy", int'(bus_a.busy), 0);
        tick();
        RSTB = 1'b1;
        saves = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saves += int'(bus_a.save);
        end
        chk("no_save_after_rst", saves, 0);
        chk("idle_after_rst", int'(bus_a.state), 0);

        // Illegal encoding recovers to ON on the next falling edge.
        force dut_a.state_q = 4'd12;
        #2 release dut_a.state_q;
        tick();
        chk("illegal_recover", int'(bus_a.state), 0);

        // Sub-cycle ack glitches in PWR_ON must not release the wait.
        bus_a.sleep_req = 1'b1;
        tick();
        bus_a.sleep_req = 1'b0;
        wait_for(1'b0, 4'd4, "glitch_pwr_off");
        bus_a.pwr_ack = 1'b0;
        wait_for(1'b0, 4'd5, "glitch_off");
        bus_a.wake_req = 1'b1;
        tick();
        bus_a.wake_req = 1'b0;
        chk("glitch_pwr_on", int'(bus_a.state), 6);
        for (int i = 0; i < 3; i++) begin
            bus_a.pwr_ack = 1'b1;
            #2 bus_a.pwr_ack = 1'b0;
            tick();
            chk("glitch_hold", int'(bus_a.state), 6);
        end
        bus_a.pwr_ack = 1'b1;
        wait_for(1'b0, 4'd0, "glitch_resume");
        chk("a_no_err", int'(bus_a.err), 0);

        // Timeout (ACK_TIMEOUT=4) with ack stuck high in PWR_OFF.
        bus_b.sleep_req = 1'b1;
        tick();
        bus_b.sleep_req = 1'b0;
        wait_for(1'b1, 4'd4, "tmo_pwr_off");
        tick();
        tick();
        tick();
        chk("tmo_err_early", int'(bus_b.err), 0);
        tick();
        chk("tmo_err_set", int'(bus_b.err), 1);
        chk("tmo_still_wait", int'(bus_b.state), 4);
        bus_b.pwr_ack = 1'b0;
        wait_for(1'b1, 4'd5, "tmo_off");
        chk("tmo_err_sticky", int'(bus_b.err), 1);

        // Reset while OFF re-enables power immediately.
        RSTB = 1'b0;
        #1;
        chk("rst_off_pwr_en", int'(bus_b.pwr_en), 1);
        chk("rst_off_state", int'(bus_b.state), 0);
        chk("rst_off_err", int'(bus_b.err), 0);
        tick();
        RSTB = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
